fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Read-side engine for the synchronous FIFO. It pops words through the FIFO read port, accounts for the one-cycle registered RAM read latency, and presents the words as a valid/ready stream. An internal output buffer gives one word per cycle throughput under continuous m_ready while every control decision uses registered state only. It sits between a sync FIFO instance and any valid/ready consumer.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
OUT_DEPTH, 3, output buffer entries; legal range 1 or more; 3 or more is required for full throughput
LVL_WIDTH, $clog2(OUT_DEPTH+1), derived width of the level output; not to be overridden

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous discard of buffered and in-flight words
fifo_rd_en  out  1  pop request to the FIFO read port
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid in the cycle after an accepted pop
m_valid  out  1  stream word valid
m_ready  in  1  consumer accepts the word
m_data  out  DATA_WIDTH  stream word
level  out  LVL_WIDTH  number of words held in the output buffer

Behaviour:
- Reset (rst=1 at posedge):
  - occupancy, inflight, read and write pointers and storage all cleared to 0.
  - m_valid=0, m_data=0, level=0.
  - fifo_rd_en is forced to 0 while rst=1.
- State:
  - Circular buffer of OUT_DEPTH entries, with rd_ptr and wr_ptr that wrap at OUT_DEPTH (not power of 2 safe: explicit wrap compare).
  - occupancy counter with range 0..OUT_DEPTH.
  - 1-bit inflight flag.
- Pop issue (combinational from registered state):
  - fifo_rd_en = !rst & !flush & !fifo_empty & (occupancy + inflight < OUT_DEPTH).
  - There is no combinational path from m_ready to fifo_rd_en.
- Inflight:
  - Set to fifo_rd_en each cycle, so at most one read is outstanding.
  - When inflight=1, fifo_rd_data is written at wr_ptr at the next posedge.
- Latency: pop in cycle N gives data sampled in N+1, and m_valid=1 with that word in N+2.
- Output:
  - m_valid = (occupancy != 0).
  - m_data = storage[rd_ptr].
  - level = occupancy.
  - Handshake when m_valid & m_ready. While m_valid=1 and m_ready=0, m_data holds stable.
- Simultaneous write and handshake in one cycle: occupancy is unchanged and both pointers advance.
- Overflow cannot occur by the credit rule. A write with occupancy==OUT_DEPTH is an assertion failure.
- flush=1 at posedge:
  - occupancy=0, pointers=0, inflight=0. The word arriving that cycle is dropped.
  - No pop is issued in the flush cycle; m_valid=0 from the next cycle.
  - Flush wins over a simultaneous handshake; that handshake does not count as a transfer.
  - The FIFO contents themselves are untouched.
- Throughput: with OUT_DEPTH>=3, m_ready=1 and a non-empty FIFO, one word per cycle is sustained. With OUT_DEPTH<3 the block is functional at reduced rate.
- Ordering: words leave in exact FIFO order, with no duplication or loss except on flush.
- fifo_rd_en is never asserted while fifo_empty=1.

Decomposition:
- No shared package; pointer and count widths are localparams derived from OUT_DEPTH.
- One natural sub-module: stream_out_buf (circular storage, pointers, occupancy, level), instantiated once. Pop-credit and inflight logic stay in the top module.
- SVA: no pop when empty, no buffer overflow, m_data stable under stall.

Test Plan:
All scenarios use DATA_WIDTH=8 and OUT_DEPTH=3.
- Reset: hold rst=1 for 3 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0x00, level=0 throughout. In the first cycle after rst falls, fifo_rd_en=1.
- Streaming: FIFO preloaded 0x01..0x10, m_ready=1 -> first m_valid two cycles after the first pop, then 16 consecutive beats 0x01..0x10 with no gap cycles.
- Backpressure: 0x01..0x10 preloaded, m_ready=0 -> exactly 3 pops then fifo_rd_en=0, level=3, m_data=0x01 stable. Raise m_ready -> 0x01,0x02,0x03,0x04... with no bubbles.
- Empty mid-stream: FIFO holds 0xA0,0xA1, then empty for 5 cycles, then 0xA2 written -> output 0xA0,0xA1,0xA2 in order; fifo_rd_en=0 in every cycle where fifo_empty=1; m_valid drops while drained.
- Flush with read in flight: 0x01..0x08 preloaded, m_ready=0; after level=2 assert flush for 1 cycle in the cycle a pop's data returns -> next cycle m_valid=0, level=0. With m_ready=1 the next word out is the first not yet popped (0x04).
- Reset mid-operation: rst=1 while level=3 and inflight=1 -> next cycle m_valid=0, level=0; the returning word is discarded; the stream restarts from the FIFO's current head.

Source files
------------

// File: rtl/stream_out_buf.sv
// Circular output buffer for the FIFO stream reader: storage, wrapping
// pointers and occupancy, presented as the valid/data side of the stream.
module stream_out_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 3,
    parameter int LVL_WIDTH  = $clog2(OUT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [LVL_WIDTH-1:0]  level
);

    localparam int PTR_WIDTH = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(OUT_DEPTH - 1);
    localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(OUT_DEPTH);

    logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [LVL_WIDTH-1:0]  occupancy;
    logic                  pop;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // A handshake coinciding with flush is discarded, not counted.
    assign pop   = valid && ready && !flush;
    assign valid = (occupancy != '0);
    assign data  = mem[rd_ptr];
    assign level = occupancy;

    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            // NOTE: storage is cleared on reset so m_data reads 0 afterwards;
            // this costs a reset on every entry and is deliberate here.
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occupancy <= occupancy + LVL_WIDTH'(1);
                2'b01:   occupancy <= occupancy - LVL_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !flush && occupancy == FULL_LVL));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the sync FIFO: issues pops against buffer credit,
// absorbs the one-cycle RAM read latency and emits a valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 3,
    parameter int LVL_WIDTH  = $clog2(OUT_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_WIDTH-1:0]  level
);

    localparam int CREDIT_WIDTH = LVL_WIDTH + 1;

    logic                    inflight;
    logic [CREDIT_WIDTH-1:0] committed;

    // Credit counts buffered plus in-flight words and ignores m_ready, so the
    // pop request depends on registered state only.
    assign committed  = CREDIT_WIDTH'(level) + CREDIT_WIDTH'(inflight);
    assign fifo_rd_en = !rst && !flush && !fifo_empty
                        && (committed < CREDIT_WIDTH'(OUT_DEPTH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_out_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_DEPTH (OUT_DEPTH),
        .LVL_WIDTH (LVL_WIDTH)
    ) u_out_buf (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_en  (inflight),
        .wr_data(fifo_rd_data),
        .ready  (m_ready),
        .valid  (m_valid),
        .data   (m_data),
        .level  (level)
    );

    a_no_pop_when_empty: assert property (@(posedge clk)
        !(fifo_rd_en && fifo_empty));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready && !flush) |=> $stable(m_data));

endmodule
